minmax_reduce_pipe: RTL and testbench

Parametrised, pipelined min/max reduction tree for the extended tensor core semiring datapath. Reduces N lane operands plus one accumulator operand to a single extremum per transaction, with min/max mode selectable per transaction. One register level per tree level gives one result per cycle at full throughput, with valid/ready flow control. It replaces the fixed-width, fixed-fan-in combinational max trees in the max-plus and min-plus reduction stage.

---
 rtl/minmax_reduce_pipe_pkg.sv | 34 +++
 rtl/minmax_reduce_pipe_if.sv | 47 ++++
 rtl/minmax_reduce_pipe_node.sv | 48 ++++
 rtl/minmax_reduce_pipe.sv | 112 +++++++++++
 tb/tb_minmax_reduce_pipe.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minmax_reduce_pipe_pkg.sv
// Shared types and elaboration-time helpers for the min/max reduction tree.
// Optional feature macro used elsewhere in this slice: MINMAX_ARGIDX_EN.
package minmax_pkg;

  typedef enum logic {
    MM_MAX = 1'b0,
    MM_MIN = 1'b1
  } mm_mode_e;

  // Number of tree levels needed to reduce 'leaves' operands to one.
  function automatic int tree_depth(input int leaves);
    int d;
    d = 0;
    while ((1 << d) < leaves) d++;
    return d;
  endfunction

  // Survivor count after 'lv' pairing levels (ceil(n/2) applied lv times).
  function automatic int level_width(input int leaves, input int lv);
    int n;
    n = leaves;
    for (int i = 0; i < lv; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // First element position of stage 'lv' when all stages are packed back to back.
  function automatic int level_offset(input int leaves, input int lv);
    int off;
    off = 0;
    for (int i = 0; i < lv; i++) off += level_width(leaves, i);
    return off;
  endfunction

endpackage

// File: rtl/minmax_reduce_pipe_if.sv
// Valid/ready bus for the min/max reduction pipe: input transaction side and
// result side bundled together. out_idx exists only when MINMAX_ARGIDX_EN is defined.
interface minmax_reduce_pipe_if #(
  parameter int W = 16,
  parameter int N = 16
);
  import minmax_pkg::*;

`ifdef MINMAX_ARGIDX_EN
  localparam int IW = tree_depth(N + 1);
`endif

  logic           in_valid;
  logic           in_ready;
  logic           in_mode;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   in_acc;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
`ifdef MINMAX_ARGIDX_EN
  logic [IW-1:0]  out_idx;
`endif

`ifdef MINMAX_ARGIDX_EN
  modport master (
    output in_valid, in_mode, in_data, in_acc, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_acc, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
`else
  modport master (
    output in_valid, in_mode, in_data, in_acc, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_acc, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/minmax_reduce_pipe_node.sv
// One combinational compare-select node of the reduction tree. Ties keep the
// left operand so the lowest leaf index wins. With MINMAX_ARGIDX_EN defined the
// node also forwards the index of the selected operand.
module minmax_node
  import minmax_pkg::*;
#(
  parameter int W      = 16,
  parameter int SIGNED = 0
`ifdef MINMAX_ARGIDX_EN
  , parameter int IW   = 1
`endif
) (
  input  logic [W-1:0]  i_l,
  input  logic [W-1:0]  i_r,
  input  mm_mode_e      i_mode,
`ifdef MINMAX_ARGIDX_EN
  input  logic [IW-1:0] i_lIdx,
  input  logic [IW-1:0] i_rIdx,
  output logic [IW-1:0] o_idx,
`endif
  output logic [W-1:0]  o_data
);

  logic w_ge;
  logic w_le;
  logic w_leftWins;

  // Compare in the configured number format, then pick the side the mode asks for
  always_comb begin
    w_ge = 1'b0;
    w_le = 1'b0;
    if (SIGNED != 0) begin
      w_ge = ($signed(i_l) >= $signed(i_r));
      w_le = ($signed(i_l) <= $signed(i_r));
    end else begin
      w_ge = (i_l >= i_r);
      w_le = (i_l <= i_r);
    end
    w_leftWins = (i_mode == MM_MAX) ? w_ge : w_le;
  end

  assign o_data = w_leftWins ? i_l : i_r;

`ifdef MINMAX_ARGIDX_EN
  assign o_idx = w_leftWins ? i_lIdx : i_rIdx;
`endif

endmodule

// File: rtl/minmax_reduce_pipe.sv
// Pipelined min/max reduction of N lanes plus an accumulator (leaf N).
// Stage 0 registers the leaves; each of the D tree levels is followed by a
// register stage, so results emerge D edges after acceptance. A single global
// enable freezes the whole pipe under backpressure.
// Optional feature: MINMAX_ARGIDX_EN adds the winning leaf index (out_idx).
module minmax_reduce_pipe
  import minmax_pkg::*;
#(
  parameter int W      = 16,
  parameter int N      = 16,
  parameter int SIGNED = 0
) (
  input logic clk,
  input logic rst,
  minmax_reduce_pipe_if.slave bus
);

  localparam int LEAVES = N + 1;
  localparam int D      = tree_depth(LEAVES);
  localparam int TOT    = level_offset(LEAVES, D + 1);
`ifdef MINMAX_ARGIDX_EN
  localparam int IW     = tree_depth(LEAVES);
`endif

  // All stage data packed back to back: stage lv element e sits at (level_offset(lv)+e)*W.
  logic [TOT*W-1:0]          r_data;
  logic [(TOT-LEAVES)*W-1:0] w_next;
  logic [D:0]                r_valid;
  logic [D-1:0]              r_mode;
  logic                      w_en;

`ifdef MINMAX_ARGIDX_EN
  logic [(TOT-LEAVES)*IW-1:0] r_idx;
  logic [(TOT-LEAVES)*IW-1:0] w_nextIdx;
  logic [LEAVES*IW-1:0]       w_leafIdx;
  logic [TOT*IW-1:0]          w_idxAll;
`endif

  assign w_en          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_valid[D];
  assign bus.out_data  = r_data[(TOT-1)*W +: W];

`ifdef MINMAX_ARGIDX_EN
  for (genvar j = 0; j < LEAVES; j++) begin : g_leafIdx
    assign w_leafIdx[j*IW +: IW] = IW'(j);
  end
  assign w_idxAll    = {r_idx, w_leafIdx};
  assign bus.out_idx = r_idx[(TOT-LEAVES-1)*IW +: IW];
`endif

  for (genvar lv = 1; lv <= D; lv++) begin : g_level
    localparam int PCNT = level_width(LEAVES, lv - 1);
    localparam int CNT  = level_width(LEAVES, lv);
    localparam int POFF = level_offset(LEAVES, lv - 1);
    localparam int NOFF = level_offset(LEAVES, lv) - LEAVES;

    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (2*j + 1 < PCNT) begin : g_pair
        minmax_node #(
          .W      (W),
          .SIGNED (SIGNED)
`ifdef MINMAX_ARGIDX_EN
          , .IW   (IW)
`endif
        ) u_node (
          .i_l    (r_data[(POFF+2*j)*W +: W]),
          .i_r    (r_data[(POFF+2*j+1)*W +: W]),
          .i_mode (mm_mode_e'(r_mode[lv-1])),
`ifdef MINMAX_ARGIDX_EN
          .i_lIdx (w_idxAll[(POFF+2*j)*IW +: IW]),
          .i_rIdx (w_idxAll[(POFF+2*j+1)*IW +: IW]),
          .o_idx  (w_nextIdx[(NOFF+j)*IW +: IW]),
`endif
          .o_data (w_next[(NOFF+j)*W +: W])
        );
      end else begin : g_pass
        assign w_next[(NOFF+j)*W +: W] = r_data[(POFF+2*j)*W +: W];
`ifdef MINMAX_ARGIDX_EN
        assign w_nextIdx[(NOFF+j)*IW +: IW] = w_idxAll[(POFF+2*j)*IW +: IW];
`endif
      end
    end
  end

  // Advance every stage (leaves, tree levels, mode and valid) together when the pipe is enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_mode  <= '0;
      r_data  <= '0;
    end else if (w_en) begin
      r_valid[0] <= bus.in_valid && w_en;
      for (int s = 1; s <= D; s++) r_valid[s] <= r_valid[s-1];
      r_mode[0] <= bus.in_mode;
      for (int s = 1; s < D; s++) r_mode[s] <= r_mode[s-1];
      r_data <= {w_next, bus.in_acc, bus.in_data};
    end
  end

`ifdef MINMAX_ARGIDX_EN
  // Winning indices ride alongside the data through the tree-level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_en) begin
      r_idx <= w_nextIdx;
    end
  end
`endif

endmodule

// File: tb/tb_minmax_reduce_pipe.sv
// Self-checking bench for minmax_reduce_pipe: an unsigned N=16 instance and a
// signed N=2 instance, compared against a straight linear-scan reference.
// Index checks are compiled in only when MINMAX_ARGIDX_EN is defined.
module tb_minmax_reduce_pipe;
  import minmax_pkg::*;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int D  = 5;
  localparam int N2 = 2;
  localparam int D2 = 2;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    int           cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cycleNo = 0;
  res_t expQ[$];
  res_t obsQ[$];

  always #5 clk = ~clk;

  minmax_reduce_pipe_if #(.W(W), .N(N))  bus ();
  minmax_reduce_pipe_if #(.W(W), .N(N2)) bus2 ();

  minmax_reduce_pipe #(.W(W), .N(N), .SIGNED(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  minmax_reduce_pipe #(.W(W), .N(N2), .SIGNED(1)) dutSigned (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Linear scan over leaves 0..nLanes (last is acc); strict improvement keeps the lowest index on ties
  function automatic res_t refReduce(input logic [N*W-1:0] lanes, input logic [W-1:0] acc,
                                     input logic mode, input int nLanes, input bit isSigned);
    res_t r;
    longint v;
    longint best;
    logic [W-1:0] raw;
    best = 0;
    r.data = '0;
    r.idx = 0;
    r.cyc = 0;
    for (int k = 0; k <= nLanes; k++) begin
      raw = (k == nLanes) ? acc : lanes[k*W +: W];
      v = isSigned ? longint'($signed(raw)) : longint'(raw);
      if (k == 0 || (mode ? (v < best) : (v > best))) begin
        best = v;
        r.data = raw;
        r.idx = k;
      end
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] randLanes();
    logic [N*W-1:0] l;
    for (int k = 0; k < N; k++)
      l[k*W +: W] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
    return l;
  endfunction

  // Drive one cycle on the unsigned instance and log what the next edge will accept/deliver
  task automatic stepCycle(input logic rstIn, input logic v, input logic mode,
                           input logic [N*W-1:0] lanes, input logic [W-1:0] acc, input logic ordy);
    res_t e;
    res_t o;
    @(negedge clk);
    rst = rstIn;
    bus.in_valid = v;
    bus.in_mode = mode;
    bus.in_data = lanes;
    bus.in_acc = acc;
    bus.out_ready = ordy;
    #1;
    cycleNo++;
    if (!rstIn && v && bus.in_ready) begin
      e = refReduce(lanes, acc, mode, N, 1'b0);
      e.cyc = cycleNo;
      expQ.push_back(e);
    end
    if (!rstIn && bus.out_valid && ordy) begin
      o.data = bus.out_data;
`ifdef MINMAX_ARGIDX_EN
      o.idx = int'(bus.out_idx);
`else
      o.idx = -1;
`endif
      o.cyc = cycleNo;
      obsQ.push_back(o);
    end
  endtask

  task automatic stepIdle(input logic ordy);
    stepCycle(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  // Run idle cycles until every accepted transaction has emerged, then a few more to expose duplicates
  task automatic drainPipe(input int budget, output bit timedOut);
    int n;
    n = 0;
    while (obsQ.size() < expQ.size() && n < budget) begin
      stepIdle(1'b1);
      n++;
    end
    timedOut = (obsQ.size() < expQ.size());
    repeat (D + 2) stepIdle(1'b1);
  endtask

  // Drive one cycle on the signed N=2 instance
  task automatic stepSigned(input logic v, input logic mode, input logic [N2*W-1:0] lanes,
                            input logic [W-1:0] acc);
    res_t e;
    res_t o;
    logic [N*W-1:0] wide;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus2.in_valid = v;
    bus2.in_mode = mode;
    bus2.in_data = lanes;
    bus2.in_acc = acc;
    bus2.out_ready = 1'b1;
    #1;
    cycleNo++;
    if (v && bus2.in_ready) begin
      wide = '0;
      wide[N2*W-1:0] = lanes;
      e = refReduce(wide, acc, mode, N2, 1'b1);
      e.cyc = cycleNo;
      expQ.push_back(e);
    end
    if (bus2.out_valid) begin
      o.data = bus2.out_data;
`ifdef MINMAX_ARGIDX_EN
      o.idx = int'(bus2.out_idx);
`else
      o.idx = -1;
`endif
      o.cyc = cycleNo;
      obsQ.push_back(o);
    end
  endtask

  task automatic test_reset();
    stepCycle(1'b1, 1'b1, 1'b0, randLanes(), 16'h1234, 1'b1);
    stepCycle(1'b1, 1'b1, 1'b1, randLanes(), 16'h4321, 1'b1);
    stepIdle(1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("[TB] FAIL reset_out_data: got %0h expected 0", bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
    end
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_signed_out_valid: got %0b expected 0", bus2.out_valid);
    end
`ifdef MINMAX_ARGIDX_EN
    checks++;
    if (bus.out_idx !== '0) begin
      errors++; $display("[TB] FAIL reset_out_idx: got %0d expected 0", bus.out_idx);
    end
`endif
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      errors++; $display("[TB] FAIL reset_no_traffic: got obs=%0d exp=%0d expected 0/0", obsQ.size(), expQ.size());
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_max_directed();
    logic [N*W-1:0] lanes;
    bit to;
    for (int i = 0; i < N; i++) lanes[i*W +: W] = W'(3 * i);
    stepCycle(1'b0, 1'b1, 1'b0, lanes, 16'd10, 1'b1);
    drainPipe(20, to);
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL max_timeout: got %0d results expected 1", obsQ.size());
    end
    checks++;
    if (obsQ.size() != 1) begin
      errors++; $display("[TB] FAIL max_count: got %0d expected 1", obsQ.size());
    end
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      checks++;
      if (obsQ[0].data !== 16'd45) begin
        errors++; $display("[TB] FAIL max_data: got %0d expected 45", obsQ[0].data);
      end
      checks++;
      if (obsQ[0].cyc - expQ[0].cyc - 1 != D) begin
        errors++; $display("[TB] FAIL max_latency: got %0d expected %0d", obsQ[0].cyc - expQ[0].cyc - 1, D);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[0].idx != 15) begin
        errors++; $display("[TB] FAIL max_idx: got %0d expected 15", obsQ[0].idx);
      end
`endif
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_min_tie();
    logic [N*W-1:0] lanes;
    bit to;
    for (int i = 0; i < N; i++) lanes[i*W +: W] = W'(3 * i);
    stepCycle(1'b0, 1'b1, 1'b1, lanes, 16'd0, 1'b1);
    drainPipe(20, to);
    checks++;
    if (to || obsQ.size() != 1) begin
      errors++; $display("[TB] FAIL min_tie_count: got %0d expected 1", obsQ.size());
    end
    if (obsQ.size() > 0) begin
      checks++;
      if (obsQ[0].data !== 16'd0) begin
        errors++; $display("[TB] FAIL min_tie_data: got %0d expected 0", obsQ[0].data);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[0].idx != 0) begin
        errors++; $display("[TB] FAIL min_tie_idx: got %0d expected 0", obsQ[0].idx);
      end
`endif
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int i = 0; i < 8; i++)
      stepCycle(1'b0, 1'b1, logic'(i % 2), randLanes(), W'($urandom), 1'b1);
    checks++;
    if (expQ.size() != 8) begin
      errors++; $display("[TB] FAIL b2b_accepted: got %0d expected 8", expQ.size());
    end
    drainPipe(30, to);
    checks++;
    if (to || obsQ.size() != expQ.size()) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i].data !== expQ[i].data) begin
        errors++; $display("[TB] FAIL b2b_data[%0d]: got %0h expected %0h", i, obsQ[i].data, expQ[i].data);
      end
      checks++;
      if (obsQ[i].cyc != obsQ[0].cyc + i) begin
        errors++; $display("[TB] FAIL b2b_consecutive[%0d]: got cycle %0d expected %0d", i, obsQ[i].cyc, obsQ[0].cyc + i);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[i].idx != expQ[i].idx) begin
        errors++; $display("[TB] FAIL b2b_idx[%0d]: got %0d expected %0d", i, obsQ[i].idx, expQ[i].idx);
      end
`endif
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_backpressure();
    bit to;
    for (int i = 0; i < 12; i++)
      stepCycle(1'b0, 1'b1, logic'($urandom_range(0, 1)), randLanes(), W'($urandom), 1'b0);
    checks++;
    if (expQ.size() != D + 1) begin
      errors++; $display("[TB] FAIL bp_fill: got %0d accepted expected %0d", expQ.size(), D + 1);
    end
    for (int i = 0; i < 3; i++) begin
      stepCycle(1'b0, 1'b1, 1'b0, randLanes(), W'($urandom), 1'b0);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_in_ready: got %0b expected 0", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_out_valid: got %0b expected 1", bus.out_valid);
      end
      if (expQ.size() > 0) begin
        checks++;
        if (bus.out_data !== expQ[0].data) begin
          errors++; $display("[TB] FAIL bp_hold_data: got %0h expected %0h", bus.out_data, expQ[0].data);
        end
      end
    end
    drainPipe(30, to);
    checks++;
    if (to || obsQ.size() != expQ.size()) begin
      errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i].data !== expQ[i].data) begin
        errors++; $display("[TB] FAIL bp_data[%0d]: got %0h expected %0h", i, obsQ[i].data, expQ[i].data);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[i].idx != expQ[i].idx) begin
        errors++; $display("[TB] FAIL bp_idx[%0d]: got %0d expected %0d", i, obsQ[i].idx, expQ[i].idx);
      end
`endif
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_random_flow();
    bit to;
    for (int i = 0; i < 60; i++)
      stepCycle(1'b0, logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
                randLanes(), W'($urandom), logic'($urandom_range(0, 9) < 6));
    drainPipe(40, to);
    checks++;
    if (to || obsQ.size() != expQ.size()) begin
      errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i].data !== expQ[i].data) begin
        errors++; $display("[TB] FAIL rand_data[%0d]: got %0h expected %0h", i, obsQ[i].data, expQ[i].data);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[i].idx != expQ[i].idx) begin
        errors++; $display("[TB] FAIL rand_idx[%0d]: got %0d expected %0d", i, obsQ[i].idx, expQ[i].idx);
      end
`endif
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++)
      stepCycle(1'b0, 1'b1, logic'(i % 2), randLanes(), W'($urandom), 1'b1);
    stepIdle(1'b1);
    stepIdle(1'b1);
    stepCycle(1'b1, 1'b1, 1'b0, randLanes(), W'($urandom), 1'b1);
    expQ.delete();
    obsQ.delete();
    stepIdle(1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_out_valid: got %0b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("[TB] FAIL midrst_out_data: got %0h expected 0", bus.out_data);
    end
    repeat (12) stepIdle(1'b1);
    checks++;
    if (obsQ.size() != 0) begin
      errors++; $display("[TB] FAIL midrst_stale: got %0d results expected 0", obsQ.size());
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_signed();
    int n;
    stepSigned(1'b1, 1'b0, {16'h0001, 16'hFFFF}, 16'h8000);
    stepSigned(1'b1, 1'b1, {16'h0001, 16'hFFFF}, 16'h8000);
    for (int i = 0; i < 10; i++)
      stepSigned(1'b1, logic'($urandom_range(0, 1)), {W'($urandom), W'($urandom)}, W'($urandom));
    n = 0;
    while (obsQ.size() < expQ.size() && n < 20) begin
      stepSigned(1'b0, 1'b0, '0, '0);
      n++;
    end
    repeat (D2 + 2) stepSigned(1'b0, 1'b0, '0, '0);
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++; $display("[TB] FAIL signed_count: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    if (obsQ.size() >= 2 && expQ.size() >= 2) begin
      checks++;
      if (obsQ[0].data !== 16'h0001) begin
        errors++; $display("[TB] FAIL signed_max: got %0h expected 0001", obsQ[0].data);
      end
      checks++;
      if (obsQ[1].data !== 16'h8000) begin
        errors++; $display("[TB] FAIL signed_min: got %0h expected 8000", obsQ[1].data);
      end
      checks++;
      if (obsQ[0].cyc - expQ[0].cyc - 1 != D2) begin
        errors++; $display("[TB] FAIL signed_latency: got %0d expected %0d", obsQ[0].cyc - expQ[0].cyc - 1, D2);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[0].idx != 1 || obsQ[1].idx != 2) begin
        errors++; $display("[TB] FAIL signed_idx: got %0d/%0d expected 1/2", obsQ[0].idx, obsQ[1].idx);
      end
`endif
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i].data !== expQ[i].data) begin
        errors++; $display("[TB] FAIL signed_data[%0d]: got %0h expected %0h", i, obsQ[i].data, expQ[i].data);
      end
`ifdef MINMAX_ARGIDX_EN
      checks++;
      if (obsQ[i].idx != expQ[i].idx) begin
        errors++; $display("[TB] FAIL signed_ridx[%0d]: got %0d expected %0d", i, obsQ[i].idx, expQ[i].idx);
      end
`endif
    end
    obsQ.delete();
    expQ.delete();
  endtask

  // Hard stop in case the simulation stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_data = '0;
    bus.in_acc = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0;
    bus2.in_mode = 1'b0;
    bus2.in_data = '0;
    bus2.in_acc = '0;
    bus2.out_ready = 1'b1;
    $display("[TB] starting minmax_reduce_pipe bench");
    test_reset();
    test_max_directed();
    test_min_tie();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_midflight();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
